switch_cmd_tx: RTL

SWITCH_CMD_TX -- requirements
Module: switch_cmd_tx

---
 rtl/switch_pkg.sv | 11 +
 rtl/switch_cmd_fifo.sv | 32 +++
 rtl/switch_cmd_tx.sv | 95 +++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: link encodings, frame length and transmitter FSM states shared by the
// switch command transmitter and the downstream receiver.
package switch_pkg;
  localparam logic [1:0] SEL_MOTOR = 2'b00;
  localparam logic [1:0] SEL_SERVO = 2'b01;
  localparam int FRAME_BITS = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_RST, ST_LEAD, ST_DATA, ST_GAP} state_t;
  function automatic logic is_reserved(input logic [1:0] sel);
    return sel[1];
  endfunction
endpackage

// File: rtl/switch_cmd_fifo.sv
// switch_cmd_fifo: frame-byte queue; pointers carry an extra wrap bit so that
// full and empty stay distinct when the indices coincide.
module switch_cmd_fifo import switch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FRAME_BITS-1:0] din,
  output logic [FRAME_BITS-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr, rd;
  logic [FRAME_BITS-1:0] mem [DEPTH];
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk)
    if (reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
    end
endmodule

// File: rtl/switch_cmd_tx.sv
// switch_cmd_tx: serialises {cmd_data, cmd_sel} frames to the switcher link.
// SWITCH_CMD_TX_FIFO_EN selects a FIFO_DEPTH queue instead of one holding register.
module switch_cmd_tx import switch_pkg::*; #(
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic [5:0] cmd_data,
  output logic       link_rst,
  output logic       sda,
  output logic       busy,
  output logic       cmd_err
);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
  state_t state;
  logic [3:0] cnt;
  logic [FRAME_BITS-1:0] shift, head;
  logic rdy_en, accept, push, pop, empty, pending;
  assign accept = cmd_valid && cmd_ready;
  assign push = accept && !is_reserved(cmd_sel);
  assign pop = state == ST_RST;
  // a push in IDLE starts the frame at the same edge, giving link_rst one cycle after accept
  assign pending = push || !empty;
  assign busy = state != ST_IDLE || !empty;
`ifdef SWITCH_CMD_TX_FIFO_EN
  logic full;
  assign cmd_ready = rdy_en && (!full || pop);
  switch_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din({cmd_data, cmd_sel}), .dout(head), .full(full), .empty(empty)
  );
`else
  localparam int unused_depth = FIFO_DEPTH;
  logic held;
  assign empty = !held;
  assign cmd_ready = rdy_en && state == ST_IDLE && !held;
  always_ff @(posedge clk)
    if (reset) held <= 1'b0;
    else if (push) begin
      held <= 1'b1;
      head <= {cmd_data, cmd_sel};
    end else if (pop) held <= 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      link_rst <= 1'b1;
      sda <= 1'b0;
      cnt <= '0;
      shift <= '0;
      rdy_en <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      link_rst <= 1'b0;
      sda <= 1'b0;
      rdy_en <= 1'b1;
      cmd_err <= accept && is_reserved(cmd_sel);
      case (state)
        ST_IDLE: if (pending) begin
          state <= ST_RST;
          link_rst <= 1'b1;
        end
        ST_RST: begin
          state <= ST_LEAD;
          shift <= head;
        end
        ST_LEAD: begin
          state <= ST_DATA;
          cnt <= '0;
          sda <= shift[0];
          shift <= shift >> 1;
        end
        ST_DATA: if (cnt == BIT_LAST) begin
          state <= ST_GAP;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          sda <= shift[0];
          shift <= shift >> 1;
        end
        ST_GAP: if (cnt != GAP_LAST) cnt <= cnt + 1'b1;
        else begin
          cnt <= '0;
          state <= pending ? ST_RST : ST_IDLE;
          link_rst <= pending;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
